// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: shared state encodings, defaults and byte-merge helper
package dm_responder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam int DEPTH_DEFAULT = 3072;
  localparam logic [3:0] BYTEEN_READ = 4'b0000;
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
    for (int i = 0; i < 4; i++) merge_bytes[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
  endfunction
endpackage

// File: rtl/dm_byte_ram.sv
// dm_byte_ram: DEPTH x 32 storage with byte-lane write and asynchronous word read
module dm_byte_ram
  import dm_responder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic [3:0]    byteen,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  // commit only the enabled lanes; other lanes keep their stored bytes
  always_ff @(posedge clk) begin
    if (we) for (int i = 0; i < 4; i++) if (byteen[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
  assign rdata = mem[idx];
endmodule

// File: rtl/dm_responder.sv
// dm_responder: wait-stated data-memory responder with req/ready handshake and write trace
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m_data_req,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic        m_data_ready,
  output logic [31:0] m_data_rdata,
  output logic        m_data_err,
  output logic        w_valid,
  output logic [31:0] w_addr,
  output logic [31:0] w_data,
  output logic [3:0]  w_byteen
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WLOAD = 4'(WAIT_CYCLES - 1);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, be_q, be_d, w_byteen_q, w_byteen_d, be_s;
  logic [29:0] idx_q, idx_d, idx_s;
  logic [31:0] wdata_q, wdata_d, wd_s, ram_rdata, new_word;
  logic [31:0] rdata_q, rdata_d, w_addr_q, w_addr_d, w_data_q, w_data_d;
  logic        ready_q, ready_d, err_q, err_d, w_valid_q, w_valid_d;
  logic        accept, commit, in_range, we;
  logic        unused_addr;
  assign unused_addr = ^m_data_addr[1:0];
  dm_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .idx   (idx_s[AW-1:0]),
    .wdata (wd_s),
    .byteen(be_s),
    .rdata (ram_rdata)
  );
  // with zero wait states the commit happens on the accepting edge, so the live request fields are used while idle
  always_comb begin
    accept     = state_q == IDLE && m_data_req;
    idx_s      = state_q == IDLE ? m_data_addr[31:2] : idx_q;
    wd_s       = state_q == IDLE ? m_data_wdata : wdata_q;
    be_s       = state_q == IDLE ? m_data_byteen : be_q;
    commit     = (accept && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd0);
    in_range   = 32'(idx_s) < 32'(DEPTH);
    we         = commit && in_range && be_s != BYTEEN_READ;
    new_word   = merge_bytes(ram_rdata, wd_s, be_s);
    state_d    = commit ? RESP : state_q == RESP ? IDLE : accept ? WAIT : state_q;
    cnt_d      = state_q == IDLE ? WLOAD : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    idx_d      = accept ? m_data_addr[31:2] : idx_q;
    wdata_d    = accept ? m_data_wdata : wdata_q;
    be_d       = accept ? m_data_byteen : be_q;
    ready_d    = commit;
    err_d      = commit && !in_range;
    w_valid_d  = we;
    rdata_d    = commit ? (in_range ? new_word : 32'd0) : rdata_q;
    w_addr_d   = we ? {idx_s, 2'b00} : w_addr_q;
    w_data_d   = we ? new_word : w_data_q;
    w_byteen_d = we ? be_s : w_byteen_q;
  end
  // FSM, counter, capture register and registered response outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      w_valid_q  <= 1'b0;
      rdata_q    <= '0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      w_byteen_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      w_valid_q  <= w_valid_d;
      rdata_q    <= rdata_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      w_byteen_q <= w_byteen_d;
    end
  end
  assign m_data_ready = ready_q;
  assign m_data_rdata = rdata_q;
  assign m_data_err   = err_q;
  assign w_valid      = w_valid_q;
  assign w_addr       = w_addr_q;
  assign w_data       = w_data_q;
  assign w_byteen     = w_byteen_q;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: scoreboard bench for a zero-wait and a three-wait responder
module tb_dm_responder;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        wv;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [31:0] cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0]       req = '0;
  logic [1:0][31:0] addr = '0;
  logic [1:0][31:0] wdat = '0;
  logic [1:0][3:0]  be = '0;
  logic [1:0]       rdy, err, wv;
  logic [1:0][31:0] rdata, waddr, wdata;
  logic [1:0][3:0]  wbe;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dm_responder #(.DEPTH(3072), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .m_data_req(req[0]), .m_data_addr(addr[0]),
    .m_data_wdata(wdat[0]), .m_data_byteen(be[0]), .m_data_ready(rdy[0]),
    .m_data_rdata(rdata[0]), .m_data_err(err[0]), .w_valid(wv[0]),
    .w_addr(waddr[0]), .w_data(wdata[0]), .w_byteen(wbe[0])
  );
  dm_responder #(.DEPTH(3072), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .m_data_req(req[1]), .m_data_addr(addr[1]),
    .m_data_wdata(wdat[1]), .m_data_byteen(be[1]), .m_data_ready(rdy[1]),
    .m_data_rdata(rdata[1]), .m_data_err(err[1]), .w_valid(wv[1]),
    .w_addr(waddr[1]), .w_data(wdata[1]), .w_byteen(wbe[1])
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic compare(input int i, input exp_t e);
    chk($sformatf("dut%0d_rdata", i), rdata[i], e.rdata);
    chk($sformatf("dut%0d_err", i), 32'(err[i]), 32'(e.err));
    chk($sformatf("dut%0d_w_valid", i), 32'(wv[i]), 32'(e.wv));
    chk($sformatf("dut%0d_latency_cycle", i), 32'(cyc), e.cyc);
    if (e.wv) begin
      chk($sformatf("dut%0d_w_addr", i), waddr[i], e.waddr);
      chk($sformatf("dut%0d_w_data", i), wdata[i], e.wdata);
      chk($sformatf("dut%0d_w_byteen", i), 32'(wbe[i]), 32'(e.wbe));
    end
  endtask
  function automatic exp_t mk(input int i, input logic [31:0] a, input logic [3:0] b, input logic [31:0] word, input bit e_err, input int ready_cyc);
    exp_t e;
    e.rdata = e_err ? 32'd0 : word;
    e.err   = e_err;
    e.wv    = !e_err && b != 4'b0000;
    e.waddr = {a[31:2], 2'b00};
    e.wdata = word;
    e.wbe   = b;
    e.cyc   = 32'(ready_cyc);
    return e;
  endfunction
  task automatic push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask
  task automatic drive(input int i, input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req[i] = r;
    addr[i] = a;
    wdat[i] = d;
    be[i] = b;
  endtask
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, input logic [31:0] word, input bit e_err);
    bit got = 0;
    @(negedge clk);
    drive(i, 1'b1, a, d, b);
    push(i, mk(i, a, b, word, e_err, cyc + 1 + (i == 0 ? 0 : 3)));
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = rdy[i];
    end
    req[i] = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d_ready_timeout: got no ready expected ready within 40 cycles", i);
    end
  endtask
  // scoreboard monitors: every ready pops one expectation, an unexpected ready is a failure
  always @(negedge clk) begin
    if (reset_n && rdy[0]) begin
      if (q0.size() == 0) chk("dut0_unexpected_ready", 32'(rdy[0]), 32'd0);
      else compare(0, q0.pop_front());
    end
  end
  always @(negedge clk) begin
    if (reset_n && rdy[1]) begin
      if (q1.size() == 0) chk("dut1_unexpected_ready", 32'(rdy[1]), 32'd0);
      else compare(1, q1.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_ready%0d", i), 32'(rdy[i]), 0);
      chk($sformatf("reset_err%0d", i), 32'(err[i]), 0);
      chk($sformatf("reset_w_valid%0d", i), 32'(wv[i]), 0);
      chk($sformatf("reset_rdata%0d", i), rdata[i], 0);
    end
    reset_n = 1'b1;
    issue(0, 32'h10, 32'h12345678, 4'b1111, 32'h12345678, 0);
    issue(0, 32'h10, 32'h0, 4'b0000, 32'h12345678, 0);
    issue(0, 32'h20, 32'hAABBCCDD, 4'b1111, 32'hAABBCCDD, 0);
    issue(0, 32'h22, 32'h55665566, 4'b1100, 32'h5566CCDD, 0);
    issue(0, 32'h21, 32'h77777777, 4'b0010, 32'h556677DD, 0);
    issue(0, 32'h20, 32'h0, 4'b0000, 32'h556677DD, 0);
    issue(0, 32'h24, 32'hFFFFFFFF, 4'b1111, 32'hFFFFFFFF, 0);
    issue(0, 32'h24, 32'h11223344, 4'b0101, 32'hFF22FF44, 0);
    issue(0, 32'h2FFC, 32'h0BADBEEF, 4'b1111, 32'h0BADBEEF, 0);
    issue(0, 32'h3000, 32'h0, 4'b0000, 32'h0, 1);
    issue(0, 32'h3000, 32'hDEADDEAD, 4'b1111, 32'h0, 1);
    issue(0, 32'h4010, 32'hDEADDEAD, 4'b1111, 32'h0, 1);
    issue(0, 32'hFFFFFFFC, 32'hDEADDEAD, 4'b1111, 32'h0, 1);
    issue(0, 32'h2FFC, 32'h0, 4'b0000, 32'h0BADBEEF, 0);
    issue(0, 32'h10, 32'h0, 4'b0000, 32'h12345678, 0);
    @(negedge clk);
    drive(0, 1'b1, 32'h10, 32'h0, 4'b0000);
    for (int k = 1; k <= 5; k += 2) push(0, mk(0, 32'h10, 4'b0000, 32'h12345678, 0, cyc + k));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready_c%0d", k), 32'(rdy[0]), 32'(k % 2));
    end
    req[0] = 1'b0;
    issue(0, 32'h50, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_resp_ready", 32'(rdy[0]), 0);
    chk("rst_resp_w_valid", 32'(wv[0]), 0);
    chk("rst_resp_rdata", rdata[0], 0);
    chk("rst_resp_w_data", wdata[0], 0);
    @(negedge clk) reset_n = 1'b1;
    issue(0, 32'h50, 32'h0, 4'b0000, 32'hCAFEF00D, 0);
    issue(1, 32'h100, 32'hA5A5A5A5, 4'b1111, 32'hA5A5A5A5, 0);
    @(negedge clk);
    drive(1, 1'b1, 32'h100, 32'h0, 4'b0000);
    push(1, mk(1, 32'h100, 4'b0000, 32'hA5A5A5A5, 0, cyc + 4));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("w3_ready_c%0d", k), 32'(rdy[1]), 32'(k == 4));
      req[1] = (k == 2 || k == 3);
    end
    repeat (6) @(negedge clk);
    issue(1, 32'h40, 32'h0, 4'b1111, 32'h0, 0);
    issue(1, 32'h44, 32'h13572468, 4'b1111, 32'h13572468, 0);
    @(negedge clk);
    drive(1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    req[1] = 1'b0;
    #1;
    chk("rst_wait_ready", 32'(rdy[1]), 0);
    chk("rst_wait_rdata", rdata[1], 0);
    chk("rst_wait_w_addr", waddr[1], 0);
    chk("rst_wait_w_data", wdata[1], 0);
    chk("rst_wait_w_byteen", 32'(wbe[1]), 0);
    @(negedge clk) reset_n = 1'b1;
    issue(1, 32'h40, 32'h0, 4'b0000, 32'h0, 0);
    issue(1, 32'h44, 32'h0, 4'b0000, 32'h13572468, 0);
    repeat (8) @(negedge clk);
    chk("sb_empty0", 32'(q0.size()), 0);
    chk("sb_empty1", 32'(q1.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
